// File: rtl/pe_array_v2.sv
// -----------------------------------------------------------------------------
// pe_array_v2 -- linear array of ARRAY_NUM multiply-accumulate PEs.
//
// A weight stream enters PE0 and ripples one PE per cycle towards the last PE.
// Each PE multiplies its cached data lane by the weight currently at its stage
// and accumulates the product. A drain request lets the weight pipe flush, then
// emits all accumulators requantised (arithmetic right shift + saturation) as a
// single one-cycle result pulse, and clears the accumulators.
//
// Optional feature macro: PE_ARRAY_ROUND_EN
//   defined   -> round half up before the requantisation shift
//   undefined -> plain arithmetic shift (truncate toward -inf)
//
// Ports
//   iClk              clock, all logic on the rising edge
//   iRst              synchronous active-high reset
//   iValid            iWeight valid this cycle
//   iWeight           signed weight entering PE0
//   iData             signed data lanes, lane i at [(i+1)*DATA_W-1 : i*DATA_W]
//   iCfsPassDataLeft  per lane i: take cache of lane i+1 instead of iData lane i
//   iClearAcc         zero all accumulators (IDLE/ACCUM only)
//   iDrain            single-cycle request to emit results
//   iCfsOutputShift   requantisation right-shift amount, latched on drain
//   oWeight           weight leaving the last PE (for chaining)
//   oWeightValid      valid travelling with oWeight
//   oResult           requantised results, same lane order as iData
//   oResultValid      one-cycle pulse, oResult holds until the next pulse
//   oBusy             high while draining / emitting
//   oDbgState         current FSM state (0 IDLE, 1 ACCUM, 2 DRAIN, 3 OUT)
//
// Handshake: there is no back-pressure. A weight is taken whenever iValid is
// high outside DRAIN; a drain is taken whenever iDrain is high in IDLE/ACCUM.
// oResultValid is a pure pulse with no ready; the consumer must capture it.
// -----------------------------------------------------------------------------
module pe_array_v2 #(
  parameter int ARRAY_NUM = 3,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 20
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic                          iValid,
  input  logic [DATA_W-1:0]             iWeight,
  input  logic [DATA_W*ARRAY_NUM-1:0]   iData,
  input  logic [ARRAY_NUM-2:0]          iCfsPassDataLeft,
  input  logic                          iClearAcc,
  input  logic                          iDrain,
  input  logic [4:0]                    iCfsOutputShift,
  output logic [DATA_W-1:0]             oWeight,
  output logic                          oWeightValid,
  output logic [DATA_W*ARRAY_NUM-1:0]   oResult,
  output logic                          oResultValid,
  output logic                          oBusy,
  output logic [1:0]                    oDbgState
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(ARRAY_NUM + 1);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(DATA_W-1) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(2**(DATA_W-1)));

  state_t                      state;
  logic [CNT_W-1:0]            cnt;
  logic [4:0]                  shift_q;

  logic signed [DATA_W-1:0]    cache [ARRAY_NUM];
  logic signed [DATA_W-1:0]    wgt   [ARRAY_NUM];
  logic                        vld   [ARRAY_NUM];
  logic signed [ACC_W-1:0]     acc   [ARRAY_NUM];
  logic signed [2*DATA_W-1:0]  prod  [ARRAY_NUM];
  logic signed [ACC_W:0]       biased  [ARRAY_NUM];
  logic signed [ACC_W:0]       shifted [ARRAY_NUM];
  logic [DATA_W*ARRAY_NUM-1:0] result_next;

  logic acc_open;
  logic weight_accept;
  logic clear_acc;

  // MAC/clear/drain requests are honoured only while collecting samples.
  assign acc_open      = (state == ST_IDLE) || (state == ST_ACCUM);
  assign weight_accept = iValid && (state != ST_DRAIN);
  assign clear_acc     = iClearAcc && acc_open;

  assign oWeight      = wgt[ARRAY_NUM-1];
  assign oWeightValid = vld[ARRAY_NUM-1];
  assign oDbgState    = state;

  // ---------------------------------------------------------------------------
  // Data cache and weight pipe. With pass-left set, lane i copies the cache of
  // lane i+1, so each hop adds one cycle of skew relative to the source lane.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int i = 0; i < ARRAY_NUM; i++) begin
        cache[i] <= '0;
        wgt[i]   <= '0;
        vld[i]   <= 1'b0;
      end
    end else begin
      cache[ARRAY_NUM-1] <= iData[(ARRAY_NUM-1)*DATA_W +: DATA_W];
      for (int i = 0; i < ARRAY_NUM-1; i++) begin
        cache[i] <= iCfsPassDataLeft[i] ? cache[i+1] : iData[i*DATA_W +: DATA_W];
      end
      wgt[0] <= iWeight;
      vld[0] <= weight_accept;
      for (int i = 1; i < ARRAY_NUM; i++) begin
        wgt[i] <= wgt[i-1];
        vld[i] <= vld[i-1];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ARRAY_NUM; i++) begin
      prod[i] = cache[i] * wgt[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulators. Weights only ever enter the pipe outside DRAIN, so every valid
  // stage belongs to a sample accepted in IDLE/ACCUM; letting it finish while
  // the FSM sits in DRAIN is what flushes the last samples into the result.
  // Clear (explicit or after OUT) wins over any MAC in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int i = 0; i < ARRAY_NUM; i++) acc[i] <= '0;
    end else if (clear_acc || (state == ST_OUT)) begin
      for (int i = 0; i < ARRAY_NUM; i++) acc[i] <= '0;
    end else begin
      for (int i = 0; i < ARRAY_NUM; i++) begin
        if (vld[i]) acc[i] <= acc[i] + ACC_W'(prod[i]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Requantisation: optional rounding bias, arithmetic shift, saturation.
  // One extra bit of headroom keeps the rounding bias from overflowing.
  // ---------------------------------------------------------------------------
  always_comb begin
    result_next = '0;
    for (int i = 0; i < ARRAY_NUM; i++) begin
      biased[i] = {acc[i][ACC_W-1], acc[i]};
`ifdef PE_ARRAY_ROUND_EN
      if (shift_q != 5'd0) begin
        biased[i] = biased[i] + ((ACC_W+1)'(1) << (shift_q - 5'd1));
      end
`endif
      shifted[i] = biased[i] >>> shift_q;
      if (shifted[i] > SAT_MAX) begin
        result_next[i*DATA_W +: DATA_W] = SAT_MAX[DATA_W-1:0];
      end else if (shifted[i] < SAT_MIN) begin
        result_next[i*DATA_W +: DATA_W] = SAT_MIN[DATA_W-1:0];
      end else begin
        result_next[i*DATA_W +: DATA_W] = shifted[i][DATA_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM. DRAIN lasts exactly ARRAY_NUM cycles, which is how long the
  // last accepted weight needs to reach the final PE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      shift_q      <= '0;
      oBusy        <= 1'b0;
      oResult      <= '0;
      oResultValid <= 1'b0;
    end else begin
      oResultValid <= 1'b0;
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (iDrain) begin
            state   <= ST_DRAIN;
            oBusy   <= 1'b1;
            cnt     <= CNT_W'(ARRAY_NUM);
            // Out-of-range shifts saturate to the widest meaningful shift.
            shift_q <= (int'(iCfsOutputShift) >= ACC_W) ? 5'(ACC_W - 1)
                                                        : iCfsOutputShift;
          end else if (iValid) begin
            state <= ST_ACCUM;
          end
        end
        ST_DRAIN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= ST_OUT;
        end
        ST_OUT: begin
          oResult      <= result_next;
          oResultValid <= 1'b1;
          oBusy        <= 1'b0;
          state        <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_array_v2.sv
// -----------------------------------------------------------------------------
// Testbench for pe_array_v2 (ARRAY_NUM=3, DATA_W=8, ACC_W=20).
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge. Expected result vectors and their arrival cycle are queued when a
// drain is issued and popped by a monitor when oResultValid pulses.
// -----------------------------------------------------------------------------
module tb_pe_array_v2;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 20;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              iRst = 1'b1;
  logic              iValid = 1'b0;
  logic [DW-1:0]     iWeight = '0;
  logic [DW*N-1:0]   iData = '0;
  logic [N-2:0]      iCfsPassDataLeft = '0;
  logic              iClearAcc = 1'b0;
  logic              iDrain = 1'b0;
  logic [4:0]        iCfsOutputShift = '0;
  logic [DW-1:0]     oWeight;
  logic              oWeightValid;
  logic [DW*N-1:0]   oResult;
  logic              oResultValid;
  logic              oBusy;
  logic [1:0]        oDbgState;

  pe_array_v2 #(.ARRAY_NUM(N), .DATA_W(DW), .ACC_W(AW)) dut (
    .iClk(clk), .iRst(iRst), .iValid(iValid), .iWeight(iWeight), .iData(iData),
    .iCfsPassDataLeft(iCfsPassDataLeft), .iClearAcc(iClearAcc), .iDrain(iDrain),
    .iCfsOutputShift(iCfsOutputShift), .oWeight(oWeight), .oWeightValid(oWeightValid),
    .oResult(oResult), .oResultValid(oResultValid), .oBusy(oBusy), .oDbgState(oDbgState)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc++;

  // scoreboard
  logic [DW*N-1:0] exp_q[$];
  int              exp_t_q[$];
  longint          acc_m[N];
  int              dat_m[N];

  always @(negedge clk) begin
    if (oResultValid === 1'b1) begin
      logic [DW*N-1:0] e;
      int t;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got %h at cycle %0d, none expected", oResult, cyc);
      end else begin
        e = exp_q.pop_front();
        t = exp_t_q.pop_front();
        if (oResult !== e || cyc !== t) begin
          n_fail++;
          $display("FAIL result: got %h at cycle %0d, expected %h at cycle %0d",
                   oResult, cyc, e, t);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver helpers
  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [DW*N-1:0] pack3(int l0, int l1, int l2);
    return {DW'(l2), DW'(l1), DW'(l0)};
  endfunction

  function automatic logic [DW*N-1:0] model_result(int sh);
    logic [DW*N-1:0] r;
    longint a;
    int s;
    r = '0;
    s = (sh >= AW) ? AW - 1 : sh;
    for (int i = 0; i < N; i++) begin
      a = acc_m[i];
`ifdef PE_ARRAY_ROUND_EN
      if (s > 0) a = a + (longint'(1) << (s - 1));
`endif
      a = a >>> s;
      if (a > 127) a = 127;
      else if (a < -128) a = -128;
      r[i*DW +: DW] = a[DW-1:0];
    end
    return r;
  endfunction

  task automatic set_data(int d0, int d1, int d2);
    dat_m[0] = d0; dat_m[1] = d1; dat_m[2] = d2;
    iData = pack3(d0, d1, d2);
  endtask

  task automatic send(int w, int n);
    for (int k = 0; k < n; k++) begin
      iValid  = 1'b1;
      iWeight = DW'(w);
      for (int i = 0; i < N; i++) acc_m[i] += longint'(dat_m[i]) * w;
      step();
    end
    iValid = 1'b0;
  endtask

  task automatic drain(int sh, logic [DW*N-1:0] e);
    iDrain = 1'b1;
    iCfsOutputShift = 5'(sh);
    exp_q.push_back(e);
    exp_t_q.push_back(cyc + N + 2);
    step();
    iDrain = 1'b0;
    for (int i = 0; i < N; i++) acc_m[i] = 0;
  endtask

  task automatic wait_results();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      step();
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL result_timeout: %0d results still pending, expected 0", exp_q.size());
      exp_q.delete();
      exp_t_q.delete();
    end
    step();
  endtask

  // scenarios
  task automatic test_reset();
    iRst = 1'b1;
    step();
    step();
    n_tests += 6;
    if (oResult !== '0)      begin n_fail++; $display("FAIL reset_result: got %h, expected 0", oResult); end
    if (oResultValid !== 0)  begin n_fail++; $display("FAIL reset_rvalid: got %b, expected 0", oResultValid); end
    if (oBusy !== 0)         begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", oBusy); end
    if (oWeight !== '0)      begin n_fail++; $display("FAIL reset_weight: got %h, expected 0", oWeight); end
    if (oWeightValid !== 0)  begin n_fail++; $display("FAIL reset_wvalid: got %b, expected 0", oWeightValid); end
    if (oDbgState !== 2'd0)  begin n_fail++; $display("FAIL reset_state: got %0d, expected 0", oDbgState); end
    iRst = 1'b0;
    step();
  endtask

  task automatic test_basic_mac();
    set_data(2, 3, 4);
    step();
    send(5, 1);
    step();
    step();
    n_tests += 2;
    if (oWeightValid !== 1'b1 || oWeight !== 8'd5) begin
      n_fail++;
      $display("FAIL weight_out: got v=%b w=%h, expected v=1 w=05", oWeightValid, oWeight);
    end
    step();
    if (oWeightValid !== 1'b0) begin
      n_fail++;
      $display("FAIL weight_out_end: got v=%b, expected 0", oWeightValid);
    end
    drain(0, pack3(10, 15, 20));
    n_tests++;
    if (oBusy !== 1'b1 || oDbgState !== 2'd2) begin
      n_fail++;
      $display("FAIL drain_busy: got busy=%b state=%0d, expected busy=1 state=2", oBusy, oDbgState);
    end
    wait_results();
    step();
    n_tests++;
    if (oResultValid !== 1'b0 || oResult !== pack3(10, 15, 20) || oBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL result_hold: got v=%b r=%h busy=%b, expected v=0 r=%h busy=0",
               oResultValid, oResult, oBusy, pack3(10, 15, 20));
    end
  endtask

  task automatic test_saturation();
    set_data(127, 127, 127);
    step();
    send(127, 4);
    drain(0, pack3(127, 127, 127));
    wait_results();
    send(-128, 4);
    drain(0, pack3(-128, -128, -128));
    wait_results();
    send(127, 4);
    drain(31, model_result(31));
    wait_results();
    send(-128, 4);
    drain(25, model_result(25));
    wait_results();
  endtask

  task automatic test_rounding();
    set_data(6, 5, 7);
    step();
    send(1, 1);
`ifdef PE_ARRAY_ROUND_EN
    drain(2, pack3(2, 1, 2));
`else
    drain(2, pack3(1, 1, 1));
`endif
    wait_results();
    set_data(5, -5, 6);
    step();
    send(1, 1);
`ifdef PE_ARRAY_ROUND_EN
    drain(1, pack3(3, -2, 3));
`else
    drain(1, pack3(2, -3, 3));
`endif
    wait_results();
  endtask

  task automatic test_clear();
    set_data(1, 2, 3);
    step();
    send(9, 1);
    repeat (3) step();
    // clear held with a new sample: clear must win over every MAC of it
    iClearAcc = 1'b1;
    iValid = 1'b1;
    iWeight = 8'd4;
    step();
    iValid = 1'b0;
    repeat (3) step();
    iClearAcc = 1'b0;
    drain(0, pack3(0, 0, 0));
    wait_results();
    // clear and new weights during DRAIN must be ignored
    send(2, 1);
    drain(0, pack3(2, 4, 6));
    iClearAcc = 1'b1;
    iValid = 1'b1;
    iWeight = 8'd50;
    repeat (3) step();
    iClearAcc = 1'b0;
    iValid = 1'b0;
    wait_results();
    for (int i = 0; i < N; i++) acc_m[i] = 0;
  endtask

  task automatic test_reset_mid_drain();
    set_data(1, 1, 1);
    step();
    send(3, 1);
    iDrain = 1'b1;
    step();
    iDrain = 1'b0;
    step();
    iRst = 1'b1;
    step();
    iRst = 1'b0;
    n_tests += 3;
    if (oDbgState !== 2'd0) begin n_fail++; $display("FAIL rst_drain_state: got %0d, expected 0", oDbgState); end
    if (oBusy !== 1'b0)     begin n_fail++; $display("FAIL rst_drain_busy: got %b, expected 0", oBusy); end
    if (oResult !== '0)     begin n_fail++; $display("FAIL rst_drain_result: got %h, expected 0", oResult); end
    repeat (8) step();
    for (int i = 0; i < N; i++) acc_m[i] = 0;
    drain(0, pack3(0, 0, 0));
    wait_results();
  endtask

  task automatic test_pass_left();
    logic [DW*N-1:0] e;
    iCfsPassDataLeft = 2'b11;
    for (int off = 0; off <= 4; off++) begin
      iData = pack3(55, 55, 0);
      repeat (4) step();
      for (int k = 0; k <= 6; k++) begin
        iData   = pack3(55, 55, (k == 2) ? 9 : 0);
        iValid  = (k == off);
        iWeight = 8'd1;
        step();
      end
      iValid = 1'b0;
      iData = pack3(55, 55, 0);
      repeat (2) step();
      e = pack3((off == 4) ? 9 : 0, (off == 2) ? 9 : 0, (off == 0) ? 9 : 0);
      drain(0, e);
      wait_results();
    end
    iCfsPassDataLeft = '0;
    set_data(0, 0, 0);
  endtask

  task automatic test_back_to_back();
    int ns, w, sh;
    for (int r = 0; r < 8; r++) begin
      set_data($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
               $urandom_range(0, 255) - 128);
      step();
      ns = $urandom_range(1, 5);
      if (ns > 1) begin
        for (int s = 0; s < ns - 1; s++) send($urandom_range(0, 255) - 128, 1);
      end
      // last sample shares its cycle with the drain request
      w  = $urandom_range(0, 255) - 128;
      sh = (r == 7) ? 24 : $urandom_range(0, 12);
      iValid = 1'b1;
      iWeight = DW'(w);
      for (int i = 0; i < N; i++) acc_m[i] += longint'(dat_m[i]) * w;
      drain(sh, model_result(sh));
      iValid = 1'b0;
      wait_results();
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      acc_m[i] = 0;
      dat_m[i] = 0;
    end
    test_reset();
    test_basic_mac();
    test_saturation();
    test_rounding();
    test_clear();
    test_reset_mid_drain();
    test_pass_left();
    test_back_to_back();
    repeat (4) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
